drawing_datapath: RTL and testbench

Pixel-generation datapath for the mouse-driven paint pipeline. It consumes the 3-bit state code from the drawing control FSM and returns its two handshake inputs: a move flag and a done pulse. It also drives the 160x120 VGA adapter write port (x, y, colour, plot) with cursor, brush, erase and full-screen-clear pixel sweeps. It sits between the control FSM and the VGA adapter; mouse coordinates come from the PS/2 mouse tracker.

---
 rtl/drawing_datapath_if.sv | 31 +++
 rtl/drawing_datapath.sv | 212 +++++++++++++++++++++
 tb/tb_drawing_datapath.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/drawing_datapath_if.sv
`default_nettype none
// ============================================================================
// Module      : drawing_datapath_if
// Description : Control-state, mouse and VGA write-port bundle for the
//               drawing datapath. The slave side is the datapath; the master
//               side is whatever drives the control state and consumes pixels.
// Revision    : 1.0 - initial release
// ============================================================================
interface drawing_datapath_if;
  logic [2:0] iState;
  logic [7:0] iMouseX;
  logic [6:0] iMouseY;
  logic [2:0] iColour;
  logic [7:0] oX;
  logic [6:0] oY;
  logic [2:0] oColour;
  logic       oPlot;
  logic       oDone;
  logic       oMove;

  modport master (
    output iState, iMouseX, iMouseY, iColour,
    input  oX, oY, oColour, oPlot, oDone, oMove
  );

  modport slave (
    input  iState, iMouseX, iMouseY, iColour,
    output oX, oY, oColour, oPlot, oDone, oMove
  );
endinterface
`default_nettype wire

// File: rtl/drawing_datapath.sv
`default_nettype none
// ============================================================================
// Module      : drawing_datapath
// Description : Pixel-generation datapath for the mouse paint pipeline.
//               Produces cursor, brush, erase and full-screen-clear pixel
//               sweeps on a 160x120 VGA write port, and returns the move flag
//               and sweep-done pulse to the control FSM.
//               Optional build macro: DRAW_ROUND_BRUSH_EN (rounded brush,
//               corner pixels of DRAW/ERASE squares are not plotted).
// Revision    : 1.0 - initial release
// ============================================================================
module drawing_datapath #(
  parameter int         SCREEN_W      = 160,
  parameter int         SCREEN_H      = 120,
  parameter int         CURSOR_SIZE   = 4,
  parameter int         BRUSH_SIZE    = 4,
  parameter logic [2:0] CURSOR_COLOUR = 3'b111,
  parameter logic [2:0] BG_COLOUR     = 3'b000
) (
  input  logic                iClk,
  input  logic                iResetn,
  drawing_datapath_if.slave   bus
);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_MOVE       = 3'd1,
    ST_WAIT       = 3'd2,
    ST_CLEAN      = 3'd3,
    ST_DRAW       = 3'd4,
    ST_ERASE      = 3'd5,
    ST_CLEAR_WAIT = 3'd6,
    ST_CLEAR      = 3'd7
  } state_e;

  localparam logic [7:0] c_max_x       = 8'(SCREEN_W - 1);
  localparam logic [6:0] c_max_y       = 7'(SCREEN_H - 1);
  localparam logic [7:0] c_cur_last_x  = 8'(CURSOR_SIZE - 1);
  localparam logic [6:0] c_cur_last_y  = 7'(CURSOR_SIZE - 1);
  localparam logic [7:0] c_brs_last_x  = 8'(BRUSH_SIZE - 1);
  localparam logic [6:0] c_brs_last_y  = 7'(BRUSH_SIZE - 1);

  state_e     w_state;
  logic [7:0] w_mouse_x;
  logic [6:0] w_mouse_y;
  logic       w_entry;
  logic       w_sweeping;
  logic [7:0] w_base_x;
  logic [6:0] w_base_y;
  logic [2:0] w_colour;
  logic [7:0] w_last_col;
  logic [6:0] w_last_row;
  logic [8:0] w_px;
  logic [7:0] w_py;
  logic       w_clipped;
  logic       w_in_new;
  logic       w_corner;
  logic       w_plot;
  logic       w_last_pixel;

  logic [2:0] r_prev_state;
  logic [7:0] r_cur_x;
  logic [6:0] r_cur_y;
  logic [7:0] r_new_x;
  logic [6:0] r_new_y;
  logic [7:0] r_col;
  logic [6:0] r_row;
  logic       r_finished;
  logic [2:0] r_brush_colour;
  logic [7:0] r_x;
  logic [6:0] r_y;
  logic [2:0] r_colour;
  logic       r_plot;
  logic       r_done;

  assign w_state   = state_e'(bus.iState);
  assign w_mouse_x = (bus.iMouseX > c_max_x) ? c_max_x : bus.iMouseX;
  assign w_mouse_y = (bus.iMouseY > c_max_y) ? c_max_y : bus.iMouseY;
  assign w_entry   = (bus.iState != r_prev_state);

  assign bus.oMove   = (w_state == ST_IDLE) &&
                       ((w_mouse_x != r_cur_x) || (w_mouse_y != r_cur_y));
  assign bus.oX      = r_x;
  assign bus.oY      = r_y;
  assign bus.oColour = r_colour;
  assign bus.oPlot   = r_plot;
  assign bus.oDone   = r_done;

  // Per-state sweep geometry: origin, square size and colour.
  always_comb begin
    w_sweeping = 1'b0;
    w_base_x   = r_cur_x;
    w_base_y   = r_cur_y;
    w_colour   = BG_COLOUR;
    w_last_col = c_cur_last_x;
    w_last_row = c_cur_last_y;
    case (w_state)
      ST_MOVE: begin
        w_sweeping = 1'b1;
        w_base_x   = r_new_x;
        w_base_y   = r_new_y;
        w_colour   = CURSOR_COLOUR;
      end
      ST_CLEAN: begin
        w_sweeping = 1'b1;
      end
      ST_DRAW: begin
        w_sweeping = 1'b1;
        w_colour   = r_brush_colour;
        w_last_col = c_brs_last_x;
        w_last_row = c_brs_last_y;
      end
      ST_ERASE: begin
        w_sweeping = 1'b1;
        w_last_col = c_brs_last_x;
        w_last_row = c_brs_last_y;
      end
      ST_CLEAR: begin
        w_sweeping = 1'b1;
        w_base_x   = 8'd0;
        w_base_y   = 7'd0;
        w_last_col = c_max_x;
        w_last_row = c_max_y;
      end
      default: begin
        w_sweeping = 1'b0;
      end
    endcase
  end

  // Pixel address one bit wider than the port so off-screen pixels can be clipped.
  assign w_px      = {1'b0, w_base_x} + {1'b0, r_col};
  assign w_py      = {1'b0, w_base_y} + {1'b0, r_row};
  assign w_clipped = (w_px >= 9'(SCREEN_W)) || (w_py >= 8'(SCREEN_H));

  // CLEAN must not erase pixels the freshly drawn cursor already covers.
  assign w_in_new  = (w_state == ST_CLEAN) &&
                     (w_px >= {1'b0, r_new_x}) &&
                     (w_px <  ({1'b0, r_new_x} + 9'(CURSOR_SIZE))) &&
                     (w_py >= {1'b0, r_new_y}) &&
                     (w_py <  ({1'b0, r_new_y} + 8'(CURSOR_SIZE)));

`ifdef DRAW_ROUND_BRUSH_EN
  assign w_corner  = ((w_state == ST_DRAW) || (w_state == ST_ERASE)) &&
                     ((r_col == 8'd0) || (r_col == c_brs_last_x)) &&
                     ((r_row == 7'd0) || (r_row == c_brs_last_y));
`else
  assign w_corner  = 1'b0;
`endif

  assign w_plot       = !w_clipped && !w_in_new && !w_corner;
  assign w_last_pixel = (r_col == w_last_col) && (r_row == w_last_row);

  // Entry detection, sweep counters, cursor bookkeeping and registered pixel port.
  always_ff @(posedge iClk or negedge iResetn) begin
    if (!iResetn) begin
      r_prev_state   <= ST_IDLE;
      r_cur_x        <= 8'd0;
      r_cur_y        <= 7'd0;
      r_new_x        <= 8'd0;
      r_new_y        <= 7'd0;
      r_col          <= 8'd0;
      r_row          <= 7'd0;
      r_finished     <= 1'b0;
      r_brush_colour <= 3'd0;
      r_x            <= 8'd0;
      r_y            <= 7'd0;
      r_colour       <= 3'd0;
      r_plot         <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      r_prev_state <= bus.iState;
      if (w_entry) begin
        r_col      <= 8'd0;
        r_row      <= 7'd0;
        r_finished <= 1'b0;
        r_plot     <= 1'b0;
        r_done     <= 1'b0;
        if (w_state == ST_MOVE) begin
          r_new_x <= w_mouse_x;
          r_new_y <= w_mouse_y;
        end
        if (w_state == ST_DRAW) begin
          r_brush_colour <= bus.iColour;
        end
      end else if (w_sweeping && !r_finished) begin
        r_x      <= w_px[7:0];
        r_y      <= w_py[6:0];
        r_colour <= w_colour;
        r_plot   <= w_plot;
        r_done   <= w_last_pixel;
        if (w_last_pixel) begin
          r_finished <= 1'b1;
          if (w_state == ST_CLEAN) begin
            r_cur_x <= r_new_x;
            r_cur_y <= r_new_y;
          end
        end else if (r_col == w_last_col) begin
          r_col <= 8'd0;
          r_row <= r_row + 7'd1;
        end else begin
          r_col <= r_col + 8'd1;
        end
      end else begin
        r_plot <= 1'b0;
        r_done <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_drawing_datapath.sv
`default_nettype none
// ============================================================================
// Module      : tb_drawing_datapath
// Description : Directed self-checking bench for drawing_datapath. Expected
//               values are hand-computed; DRAW_ROUND_BRUSH_EN selects the
//               rounded-brush expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_drawing_datapath;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_MOVE  = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_CLEAN = 3'd3;
  localparam logic [2:0] S_DRAW  = 3'd4;
  localparam logic [2:0] S_ERASE = 3'd5;
  localparam logic [2:0] S_CLEAR = 3'd7;

`ifdef DRAW_ROUND_BRUSH_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  typedef struct {
    int x;
    int y;
    int c;
  } pix_t;

  logic iClk = 1'b0;
  logic iResetn;

  drawing_datapath_if bus ();

  drawing_datapath dut (
    .iClk    (iClk),
    .iResetn (iResetn),
    .bus     (bus)
  );

  always #5 iClk = ~iClk;

  pix_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   done_cyc;
  int   done_x;
  int   done_y;
  int   hold_plots;
  int   hold_dones;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Enter a state and collect plotted pixels until oDone or the cycle budget.
  task automatic sweep(input logic [2:0] st, input int budget);
    pix_t p;
    bus.iState = st;
    q.delete();
    done_cyc = -1;
    done_x   = -1;
    done_y   = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge iClk);
      if (bus.oPlot) begin
        p.x = int'(bus.oX);
        p.y = int'(bus.oY);
        p.c = int'(bus.oColour);
        q.push_back(p);
      end
      if (bus.oDone) begin
        done_cyc = i;
        done_x   = int'(bus.oX);
        done_y   = int'(bus.oY);
        break;
      end
    end
  endtask

  task automatic hold(input int n);
    hold_plots = 0;
    hold_dones = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge iClk);
      if (bus.oPlot) hold_plots++;
      if (bus.oDone) hold_dones++;
    end
  endtask

  task automatic check_pix(input string tag, input int n, input int fx, input int fy,
                           input int lx, input int ly, input int col);
    int bad;
    bad = 0;
    check({tag, "_count"}, q.size(), n);
    if (q.size() > 0) begin
      check({tag, "_first"}, q[0].x * 256 + q[0].y, fx * 256 + fy);
      check({tag, "_last"}, q[q.size()-1].x * 256 + q[q.size()-1].y, lx * 256 + ly);
    end
    foreach (q[i]) if (q[i].c != col) bad++;
    check({tag, "_colour_bad"}, bad, 0);
  endtask

  // Move the cursor to (mx,my) with a full MOVE / WAIT / CLEAN round trip.
  task automatic relocate(input string tag, input int mx, input int my);
    bus.iMouseX = 8'(mx);
    bus.iMouseY = 7'(my);
    sweep(S_MOVE, 40);
    check({tag, "_move_done"}, done_cyc, 17);
    bus.iState = S_WAIT;
    hold(2);
    sweep(S_CLEAN, 40);
    check({tag, "_clean_done"}, done_cyc, 17);
    bus.iState = S_IDLE;
    hold(2);
  endtask

  initial begin
    int bad;
    iResetn     = 1'b0;
    bus.iState  = S_IDLE;
    bus.iMouseX = 8'd0;
    bus.iMouseY = 7'd0;
    bus.iColour = 3'd0;
    repeat (3) @(negedge iClk);
    check("rst_x", int'(bus.oX), 0);
    check("rst_y", int'(bus.oY), 0);
    check("rst_colour", int'(bus.oColour), 0);
    check("rst_plot", int'(bus.oPlot), 0);
    check("rst_done", int'(bus.oDone), 0);
    iResetn = 1'b1;
    @(negedge iClk);
    check("idle_move0", int'(bus.oMove), 0);
    bus.iMouseX = 8'd10;
    bus.iMouseY = 7'd20;
    #1;
    check("idle_move1", int'(bus.oMove), 1);

    // Cursor (0,0) -> (10,20)
    sweep(S_MOVE, 40);
    check_pix("move1", 16, 10, 20, 13, 23, 7);
    check("move1_done_cyc", done_cyc, 17);
    check("move1_done_xy", done_x * 256 + done_y, 13 * 256 + 23);
    hold(2);
    check("move1_hold_plot", hold_plots, 0);
    check("move1_hold_done", hold_dones, 0);
    bus.iState = S_WAIT;
    hold(3);
    check("wait_plot", hold_plots, 0);
    sweep(S_CLEAN, 40);
    check_pix("clean1", 16, 0, 0, 3, 3, 0);
    check("clean1_done_cyc", done_cyc, 17);
    bus.iState = S_IDLE;
    #1;
    check("cur_updated_move", int'(bus.oMove), 0);
    bus.iMouseX = 8'd12;
    #1;
    check("cur_12_move", int'(bus.oMove), 1);

    // Overlapping move (10,20) -> (12,20)
    sweep(S_MOVE, 40);
    check_pix("move2", 16, 12, 20, 15, 23, 7);
    bus.iState = S_WAIT;
    hold(2);
    sweep(S_CLEAN, 40);
    check_pix("clean2", 8, 10, 20, 11, 23, 0);
    bad = 0;
    foreach (q[i]) if (q[i].x != 10 && q[i].x != 11) bad++;
    check("clean2_overlap_bad", bad, 0);
    check("clean2_done_cyc", done_cyc, 17);
    bus.iState = S_IDLE;
    hold(2);

    // Corner of the screen: clipping
    bus.iMouseX = 8'd158;
    bus.iMouseY = 7'd118;
    sweep(S_MOVE, 40);
    check_pix("move_edge", 4, 158, 118, 159, 119, 7);
    check("move_edge_done_cyc", done_cyc, 17);
    bus.iState = S_WAIT;
    hold(2);
    sweep(S_CLEAN, 40);
    check("clean_edge_count", q.size(), 16);
    bus.iState = S_IDLE;
    hold(2);
    bus.iColour = 3'b100;
    sweep(S_DRAW, 40);
    check_pix("draw_edge", ROUND ? 3 : 4, ROUND ? 159 : 158, 118, 159, 119, 4);
    check("draw_edge_done_cyc", done_cyc, 17);
    bus.iState = S_IDLE;
    hold(2);
    sweep(S_ERASE, 40);
    check_pix("erase_edge", ROUND ? 3 : 4, ROUND ? 159 : 158, 118, 159, 119, 0);
    check("erase_edge_done_cyc", done_cyc, 17);
    bus.iState = S_IDLE;
    hold(2);

    // Full-screen clear
    sweep(S_CLEAR, 19300);
    check_pix("clear", 19200, 0, 0, 159, 119, 0);
    check("clear_done_cyc", done_cyc, 19201);
    check("clear_done_xy", done_x * 256 + done_y, 159 * 256 + 119);
    hold(3);
    check("clear_hold_done", hold_dones, 0);
    check("clear_hold_plot", hold_plots, 0);
    bus.iState = S_IDLE;
    hold(2);

    // Aborted DRAW then restart
    relocate("reloc50", 50, 60);
    bus.iColour = 3'b010;
    sweep(S_DRAW, 6);
    bus.iState = S_IDLE;
    check("abort_count", q.size(), ROUND ? 4 : 5);
    check("abort_no_done", done_cyc, -1);
    hold(3);
    check("abort_plot_drop", hold_plots, 0);
    check("abort_hold_done", hold_dones, 0);
    sweep(S_DRAW, 40);
    check_pix("redraw", ROUND ? 12 : 16, ROUND ? 51 : 50, 60, ROUND ? 52 : 53, 63, 2);
    check("redraw_done_cyc", done_cyc, 17);
    bus.iState = S_IDLE;
    hold(2);

    // Asynchronous reset in the middle of a clear sweep
    sweep(S_CLEAR, 10);
    check("pre_reset_plot", int'(bus.oPlot), 1);
    iResetn    = 1'b0;
    bus.iState = S_IDLE;
    #1;
    check("areset_plot", int'(bus.oPlot), 0);
    check("areset_x", int'(bus.oX), 0);
    bus.iMouseX = 8'd50;
    bus.iMouseY = 7'd60;
    #1;
    check("areset_cur_move", int'(bus.oMove), 1);
    @(negedge iClk);
    iResetn = 1'b1;
    @(negedge iClk);

    // Mouse clamping
    bus.iMouseX = 8'd250;
    bus.iMouseY = 7'd125;
    #1;
    check("clamp_move_flag", int'(bus.oMove), 1);
    sweep(S_MOVE, 40);
    check_pix("clamp_move", 1, 159, 119, 159, 119, 7);
    check("clamp_done_cyc", done_cyc, 17);
    bus.iState = S_IDLE;
    hold(2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
